// File: rtl/imem_pkg.sv
// Shared types and sizing for the instruction memory and its program loader.
package imem_pkg;

  localparam int IMEM_DEPTH = 16;
  localparam int IMEM_SEL_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    BYTES,
    WRITE,
    CHECK,
    DONE,
    ERROR
  } loader_state_t;

  typedef enum logic [1:0] {
    NONE      = 2'b00,
    BAD_COUNT = 2'b01,
    BAD_CHK   = 2'b10,
    TIMEOUT   = 2'b11
  } err_code_t;

endpackage

// File: rtl/imem_loader_timeout.sv
// Reloadable inter-byte watchdog: counts down while enabled and flags the cycle
// on which the window runs out.
module loader_timeout #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_en,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CW'(TIMEOUT_CYC);
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // A load of TIMEOUT_CYC expires on the TIMEOUT_CYC-th enabled edge after it.
  assign o_expired = i_en && (r_cnt == CW'(1));

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader: assembles little-endian words, writes them into
// IMEM and releases the core only after the frame checksum matches.
module imem_loader
  import imem_pkg::*;
#(
  parameter int DEPTH       = IMEM_DEPTH,
  parameter int SEL_W       = IMEM_SEL_W,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             s_valid,
  input  logic [7:0]       s_data,
  output logic             s_ready,
  output logic [31:0]      instr_data,
  output logic [SEL_W-1:0] instr_select,
  output logic             instr_write,
  output logic             core_rst_n,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [1:0]       err_code
);

  localparam logic [7:0] DEPTH_B = 8'(DEPTH);

  loader_state_t    r_state, w_state_next;
  err_code_t        r_err, w_err_next;
  logic [7:0]       r_n, r_chk, r_word_idx;
  logic [1:0]       r_byte_idx;
  logic [31:0]      r_word;
  logic             r_s_ready, r_instr_write, r_core_rst_n, r_busy, r_done, r_error;
  logic [31:0]      r_instr_data;
  logic [SEL_W-1:0] r_instr_select;
  logic             w_accept, w_start, w_expired, w_to_en;

  assign w_accept = s_valid && r_s_ready;
  assign w_start  = start && (r_state inside {IDLE, DONE, ERROR});
  assign w_to_en  = r_state inside {COUNT, BYTES, CHECK};

  loader_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_accept || w_start),
    .i_en      (w_to_en),
    .o_expired (w_expired)
  );

  always_comb begin
    // NOTE: defaults first so every path assigns and no latch is inferred.
    w_state_next = r_state;
    w_err_next   = r_err;
    case (r_state)
      IDLE, DONE, ERROR: begin
        if (w_start) begin
          w_state_next = COUNT;
          w_err_next   = NONE;
        end
      end
      COUNT: begin
        if (w_accept) begin
          if ((s_data == 8'd0) || (s_data > DEPTH_B)) begin
            w_state_next = ERROR;
            w_err_next   = BAD_COUNT;
          end else begin
            w_state_next = BYTES;
          end
        end else if (w_expired) begin
          w_state_next = ERROR;
          w_err_next   = TIMEOUT;
        end
      end
      BYTES: begin
        if (w_accept) begin
          if (r_byte_idx == 2'd3) w_state_next = WRITE;
        end else if (w_expired) begin
          w_state_next = ERROR;
          w_err_next   = TIMEOUT;
        end
      end
      WRITE: w_state_next = ((r_word_idx + 8'd1) == r_n) ? CHECK : BYTES;
      CHECK: begin
        if (w_accept) begin
          if (s_data == r_chk) begin
            w_state_next = DONE;
          end else begin
            w_state_next = ERROR;
            w_err_next   = BAD_CHK;
          end
        end else if (w_expired) begin
          w_state_next = ERROR;
          w_err_next   = TIMEOUT;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_err          <= NONE;
      r_n            <= '0;
      r_chk          <= '0;
      r_word_idx     <= '0;
      r_byte_idx     <= '0;
      r_word         <= '0;
      r_s_ready      <= 1'b0;
      r_instr_write  <= 1'b0;
      r_instr_data   <= '0;
      r_instr_select <= '0;
      r_core_rst_n   <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_error        <= 1'b0;
    end else begin
      // NOTE: non-blocking everywhere so each flop samples pre-edge values.
      r_state       <= w_state_next;
      r_err         <= w_err_next;
      // Status outputs are decoded from the next state so they line up with r_state.
      r_s_ready     <= w_state_next inside {COUNT, BYTES, CHECK};
      r_busy        <= w_state_next inside {COUNT, BYTES, WRITE, CHECK};
      r_core_rst_n  <= w_state_next inside {IDLE, DONE};
      r_done        <= (w_state_next == DONE);
      r_error       <= (w_state_next == ERROR);
      r_instr_write <= (w_state_next == WRITE);

      if (w_accept && (r_state == COUNT)) begin
        r_n        <= s_data;
        r_chk      <= s_data;
        r_word_idx <= '0;
        r_byte_idx <= '0;
      end

      if (w_accept && (r_state == BYTES)) begin
        r_word[{r_byte_idx, 3'b000} +: 8] <= s_data;
        r_chk      <= r_chk ^ s_data;
        r_byte_idx <= r_byte_idx + 2'd1;
        if (r_byte_idx == 2'd3) begin
          r_instr_data   <= {s_data, r_word[23:0]};
          r_instr_select <= r_word_idx[SEL_W-1:0];
        end
      end

      if (r_state == WRITE) r_word_idx <= r_word_idx + 8'd1;
    end
  end

  assign s_ready      = r_s_ready;
  assign instr_data   = r_instr_data;
  assign instr_select = r_instr_select;
  assign instr_write  = r_instr_write;
  assign core_rst_n   = r_core_rst_n;
  assign busy         = r_busy;
  assign done         = r_done;
  assign error        = r_error;
  assign err_code     = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// Directed-plus-random bench for imem_loader; expected writes and outcomes come
// from a frame-level reference model.
module tb_imem_loader;

  localparam int DEPTH = 16;
  localparam int SEL_W = 4;
  localparam int TO    = 16;

  typedef logic [31:0] wq_t[$];

  logic             clk = 1'b0;
  logic             rst_n, start, s_valid;
  logic [7:0]       s_data;
  logic             s_ready, instr_write, core_rst_n, busy, done, error;
  logic [31:0]      instr_data;
  logic [SEL_W-1:0] instr_select;
  logic [1:0]       err_code;

  int n_checks = 0;
  int n_errors = 0;

  logic [35:0] wr_q[$];
  int          rdy_viol;

  imem_loader #(.DEPTH(DEPTH), .SEL_W(SEL_W), .TIMEOUT_CYC(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .instr_data   (instr_data),
    .instr_select (instr_select),
    .instr_write  (instr_write),
    .core_rst_n   (core_rst_n),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .err_code     (err_code)
  );

  always #5 clk = ~clk;

  // Write monitor: samples just after each edge, away from the main thread's negedge.
  always @(posedge clk) begin
    #2;
    if (instr_write === 1'b1) begin
      wr_q.push_back({instr_select, instr_data});
      if (s_ready !== 1'b0) rdy_viol++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bound_fail(input string tag);
    n_checks++;
    n_errors++;
    $error("FAIL %s: wait bound expired", tag);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_s_ready"}, 32'(s_ready), 0);
    check({tag, "_wr"}, 32'(instr_write), 0);
    check({tag, "_data"}, instr_data, 0);
    check({tag, "_sel"}, 32'(instr_select), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_error"}, 32'(error), 0);
    check({tag, "_code"}, 32'(err_code), 0);
    check({tag, "_core"}, 32'(core_rst_n), 0);
  endtask

  task automatic pulse_start(input string tag);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_st_busy"}, 32'(busy), 1);
    check({tag, "_st_core"}, 32'(core_rst_n), 0);
    check({tag, "_st_done"}, 32'(done), 0);
    check({tag, "_st_err"}, 32'(error), 0);
    check({tag, "_st_code"}, 32'(err_code), 0);
  endtask

  // Presents one byte from a negedge and returns at the negedge after it is taken.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    if (gaps) begin
      int g = $urandom_range(0, 3);
      s_valid = 1'b0;
      repeat (g) @(negedge clk);
    end
    s_valid = 1'b1;
    s_data  = b;
    for (int k = 0; k < 64; k++) begin
      logic acc = s_ready;
      @(negedge clk);
      if (acc) begin
        s_valid = 1'b0;
        return;
      end
    end
    s_valid = 1'b0;
    bound_fail("byte_accept");
  endtask

  function automatic wq_t rand_words(input int n);
    wq_t q;
    for (int i = 0; i < n; i++) q.push_back($urandom);
    return q;
  endfunction

  // Reference model: frame outcome from the framing rules alone.
  task automatic run_frame(input string tag, input logic [7:0] n, input wq_t words,
                           input bit bad_chk, input bit gaps);
    logic [7:0] bytes_q[$];
    logic [7:0] chk;
    bit         bad_count;
    int         exp_code, exp_writes;
    bad_count = (n == 0) || (n > DEPTH);
    chk = n;
    bytes_q.push_back(n);
    if (!bad_count) begin
      for (int i = 0; i < int'(n); i++) begin
        for (int b = 0; b < 4; b++) begin
          logic [7:0] v = words[i][8*b +: 8];
          bytes_q.push_back(v);
          chk ^= v;
        end
      end
      bytes_q.push_back(bad_chk ? (chk ^ 8'(1 + $urandom_range(0, 254))) : chk);
    end
    exp_code   = bad_count ? 1 : (bad_chk ? 2 : 0);
    exp_writes = bad_count ? 0 : int'(n);

    wr_q.delete();
    rdy_viol = 0;
    pulse_start(tag);
    foreach (bytes_q[i]) send_byte(bytes_q[i], gaps);
    for (int k = 0; k < 20 && busy !== 1'b0; k++) @(negedge clk);

    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_nwr"}, wr_q.size(), exp_writes);
    for (int i = 0; i < wr_q.size() && i < exp_writes; i++) begin
      check($sformatf("%s_sel%0d", tag, i), 32'(wr_q[i][35:32]), i);
      check($sformatf("%s_dat%0d", tag, i), wr_q[i][31:0], words[i]);
    end
    check({tag, "_done"}, 32'(done), (exp_code == 0) ? 1 : 0);
    check({tag, "_error"}, 32'(error), (exp_code != 0) ? 1 : 0);
    check({tag, "_code"}, 32'(err_code), exp_code);
    check({tag, "_core"}, 32'(core_rst_n), (exp_code == 0) ? 1 : 0);
    check({tag, "_wr_ready"}, rdy_viol, 0);
  endtask

  initial begin
    wq_t w;
    int  nwr;
    rst_n   = 1'b0;
    start   = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_core", 32'(core_rst_n), 1);
    check("idle_ready", 32'(s_ready), 0);

    // Known good frame: 01 93 00 10 00 82.
    w = {32'h00100093};
    run_frame("good", 8'h01, w, 1'b0, 1'b0);

    w = {};
    run_frame("cnt0", 8'h00, w, 1'b0, 1'b0);
    run_frame("cnt17", 8'h11, w, 1'b0, 1'b0);

    w = rand_words(2);
    run_frame("badchk", 8'h02, w, 1'b1, 1'b0);

    // Timeout: stall after three bytes; a mid-frame start must not reload the watchdog.
    wr_q.delete();
    pulse_start("tmo");
    send_byte(8'h01, 1'b0);
    send_byte(8'h93, 1'b0);
    send_byte(8'h00, 1'b0);
    repeat (5) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("tmo_early_err", 32'(error), 0);
    check("tmo_early_busy", 32'(busy), 1);
    @(negedge clk);
    check("tmo_err", 32'(error), 1);
    check("tmo_code", 32'(err_code), 3);
    check("tmo_core", 32'(core_rst_n), 0);
    check("tmo_nwr", wr_q.size(), 0);

    w = rand_words(DEPTH);
    run_frame("full", 8'(DEPTH), w, 1'b0, 1'b0);
    run_frame("full_gaps", 8'(DEPTH), w, 1'b0, 1'b1);

    for (int f = 0; f < 6; f++) begin
      int  n  = $urandom_range(0, DEPTH + 2);
      bit  bc = ($urandom_range(0, 3) == 0);
      w = rand_words(n);
      run_frame($sformatf("rnd%0d", f), 8'(n), w, bc, 1'b1);
    end

    // Reset mid-frame after the second word is written.
    wr_q.delete();
    pulse_start("rstmid");
    send_byte(8'h04, 1'b0);
    for (int i = 0; i < 8; i++) send_byte(8'($urandom), 1'b0);
    for (int k = 0; k < 10 && wr_q.size() < 2; k++) @(negedge clk);
    check("rstmid_nwr", wr_q.size(), 2);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset("rstmid");
    nwr = wr_q.size();
    repeat (3) @(negedge clk);
    check("rstmid_nowr", wr_q.size(), nwr);
    rst_n = 1'b1;
    @(negedge clk);
    check("rstmid_core", 32'(core_rst_n), 1);
    w = rand_words(3);
    run_frame("after_rst", 8'h03, w, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
